// File: rtl/framer_pkg.sv
// framer_pkg: shared constants, state encoding and CRC-8 helpers for the packet framer
// and the receive-side checker.
package framer_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'h3c;
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    typedef logic [47:0] pkt_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CRC        = 3'd1,
        WAIT_AVAIL = 3'd2,
        WAIT_BUSY  = 3'd3,
        WAIT_DONE  = 3'd4
    } framer_state_e;

    // One MSB-first CRC-8 step: shift in a single message bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/packet_framer_crc8.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, zero seed, MSB first), one bit per enabled cycle.
// Shared with the receive-side checker.
module crc8_serial
    import framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // CRC register; clear wins over en so a new packet always starts from the zero seed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_r <= 8'h00;
        end else if (clear) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_step(crc_r, bit_in);
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/packet_framer.sv
// packet_framer: buffers payload words, frames them as {HEADER, word, crc8} and drives the
// transmitter with bounded retries. Define FRAMER_STATS_EN to add saturating statistics counters.
module packet_framer
    import framer_pkg::*;
#(
    parameter int         N_PKT     = 48,
    parameter int         DEPTH     = 4,
    parameter int         MAX_RETRY = 3,
    parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_PKT-1:0] data2send,
    output logic             start_tx,
    input  logic             avail_tx,
    input  logic [1:0]       err_code_tx,
    output logic             sent,
    output logic             dropped,
    output logic             busy
`ifdef FRAMER_STATS_EN
    ,
    output logic [15:0]      pkt_sent_cnt,
    output logic [15:0]      pkt_drop_cnt,
    output logic [15:0]      retry_cnt_total
`endif
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam int               CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             in_ready_r;
    logic             push_s;

    framer_state_e state_r;
    framer_state_e state_next_s;
    logic [31:0]   word_r;
    logic [4:0]    bit_cnt_r;
    logic [1:0]    wait_cnt_r;
    logic [7:0]    retry_r;
    logic          avail_d_r;
    pkt_t          data2send_r;
    logic          start_tx_r;
    logic          sent_r;
    logic          dropped_r;
    logic          busy_r;
    logic [7:0]    crc_s;
    logic          bit_s;
    logic          latch_s;
    logic          crc_en_s;
    logic          load_pkt_s;
    logic          start_s;
    logic          pop_s;
    logic          sent_s;
    logic          drop_s;
    logic          retry_s;
    logic          fail_s;

    assign push_s = in_valid & in_ready_r;
    assign bit_s  = word_r[5'd31 - bit_cnt_r];

    crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (latch_s),
        .en     (crc_en_s),
        .bit_in (bit_s),
        .crc    (crc_s)
    );

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, count and registered ready (reflects the full state before any pop)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != FULL_CNT);
        end
    end

    // Next-state and per-cycle control; a failed attempt is resolved after the case
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        crc_en_s     = 1'b0;
        load_pkt_s   = 1'b0;
        start_s      = 1'b0;
        pop_s        = 1'b0;
        sent_s       = 1'b0;
        drop_s       = 1'b0;
        retry_s      = 1'b0;
        fail_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != '0) begin
                    latch_s      = 1'b1;
                    state_next_s = CRC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CRC: begin
                crc_en_s = 1'b1;
                if (bit_cnt_r == 5'd31) begin
                    load_pkt_s   = 1'b1;
                    state_next_s = WAIT_AVAIL;
                end else begin
                    state_next_s = CRC;
                end
            end
            WAIT_AVAIL: begin
                if (avail_tx) begin
                    start_s      = 1'b1;
                    state_next_s = WAIT_BUSY;
                end else begin
                    state_next_s = WAIT_AVAIL;
                end
            end
            WAIT_BUSY: begin
                if (!avail_tx) begin
                    state_next_s = WAIT_DONE;
                end else if (wait_cnt_r == 2'd3) begin
                    fail_s = 1'b1;
                end else begin
                    state_next_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (avail_tx && !avail_d_r) begin
                    if (err_code_tx == 2'b00) begin
                        pop_s        = 1'b1;
                        sent_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
        if (fail_s) begin
            if (retry_r < RETRY_LIMIT) begin
                retry_s      = 1'b1;
                state_next_s = WAIT_AVAIL;
            end else begin
                pop_s        = 1'b1;
                drop_s       = 1'b1;
                state_next_s = IDLE;
            end
        end else begin
            retry_s = 1'b0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            word_r      <= 32'h0000_0000;
            bit_cnt_r   <= 5'd0;
            wait_cnt_r  <= 2'd0;
            retry_r     <= 8'd0;
            avail_d_r   <= 1'b0;
            data2send_r <= '0;
            start_tx_r  <= 1'b0;
            sent_r      <= 1'b0;
            dropped_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            avail_d_r  <= avail_tx;
            start_tx_r <= start_s;
            sent_r     <= sent_s;
            dropped_r  <= drop_s;
            busy_r     <= (state_next_s != IDLE);
            if (latch_s) begin
                word_r    <= mem_r[rd_ptr_r];
                bit_cnt_r <= 5'd0;
            end else if (crc_en_s) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            // The register still lacks the last bit here, so fold it in on the way out
            if (load_pkt_s) begin
                data2send_r <= {HEADER, word_r, crc8_step(crc_s, bit_s)};
            end
            if (start_s) begin
                wait_cnt_r <= 2'd0;
            end else if (state_r == WAIT_BUSY) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end
            if (sent_s || drop_s) begin
                retry_r <= 8'd0;
            end else if (retry_s) begin
                retry_r <= retry_r + 8'd1;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign data2send = data2send_r;
    assign start_tx  = start_tx_r;
    assign sent      = sent_r;
    assign dropped   = dropped_r;
    assign busy      = busy_r;

`ifdef FRAMER_STATS_EN
    logic [15:0] pkt_sent_cnt_r;
    logic [15:0] pkt_drop_cnt_r;
    logic [15:0] retry_cnt_total_r;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_sent_cnt_r    <= 16'h0000;
            pkt_drop_cnt_r    <= 16'h0000;
            retry_cnt_total_r <= 16'h0000;
        end else begin
            if (sent_s) begin
                pkt_sent_cnt_r <= sat_inc16(pkt_sent_cnt_r);
            end
            if (drop_s) begin
                pkt_drop_cnt_r <= sat_inc16(pkt_drop_cnt_r);
            end
            if (retry_s) begin
                retry_cnt_total_r <= sat_inc16(retry_cnt_total_r);
            end
        end
    end

    assign pkt_sent_cnt    = pkt_sent_cnt_r;
    assign pkt_drop_cnt    = pkt_drop_cnt_r;
    assign retry_cnt_total = retry_cnt_total_r;
`endif

endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: directed vector table, multi-cycle corner sequences and randomized
// traffic against a transaction-level model; statistics are checked when FRAMER_STATS_EN is defined.
module tb_packet_framer;
    import framer_pkg::*;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] data2send;
    logic        start_tx;
    logic        avail_tx;
    logic [1:0]  err_code_tx;
    logic        sent;
    logic        dropped;
    logic        busy;
`ifdef FRAMER_STATS_EN
    logic [15:0] pkt_sent_cnt;
    logic [15:0] pkt_drop_cnt;
    logic [15:0] retry_cnt_total;
`endif

    packet_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data2send   (data2send),
        .start_tx    (start_tx),
        .avail_tx    (avail_tx),
        .err_code_tx (err_code_tx),
        .sent        (sent),
        .dropped     (dropped),
        .busy        (busy)
`ifdef FRAMER_STATS_EN
        ,
        .pkt_sent_cnt    (pkt_sent_cnt),
        .pkt_drop_cnt    (pkt_drop_cnt),
        .retry_cnt_total (retry_cnt_total)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packets awaiting completion, attempts on the head packet,
    // outcome of the most recent attempt and event counts since the last reset
    pkt_t       exp_q[$];
    int         head_att = 0;
    logic       last_fail = 1'b0;
    int         n_start = 0;
    int         n_sent = 0;
    int         n_drop = 0;
    int         model_retry = 0;

    // Transmitter model controls
    logic [1:0] err_q[$];
    logic       tx_hold = 1'b0;
    logic       tx_rand = 1'b0;
    int         tx_ignore_left = 0;
    int         tx_busy_len = 3;

    typedef struct {
        logic [31:0] word;
        pkt_t        pkt;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC-8 as the remainder of {word, 8'h00} divided by x^8+x^2+x+1
    function automatic pkt_t make_pkt(input logic [31:0] w);
        logic [39:0] v;
        v = {w, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (v[i]) v = v ^ (40'h107 << (i - 8));
        end
        return {8'h3c, w, v[7:0]};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        err_q.delete();
        head_att    = 0;
        last_fail   = 1'b0;
        n_start     = 0;
        n_sent      = 0;
        n_drop      = 0;
        model_retry = 0;
    endtask

    task automatic push_word(input logic [31:0] w, input int budget, output logic ok);
        int k;
        k = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = in_ready;
        if (in_ready) exp_q.push_back(make_pkt(w));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, (k < budget), 1'b1);
    endtask

    // Transmitter model: drops avail on start, raises it tx_busy_len cycles later with a result
    initial begin
        avail_tx    = 1'b1;
        err_code_tx = 2'b00;
        forever begin
            @(negedge clk);
            if (tx_hold) begin
                avail_tx = 1'b0;
            end else if (start_tx && rst_n) begin
                if (tx_ignore_left > 0 || (tx_rand && $urandom_range(7, 0) == 0)) begin
                    if (tx_ignore_left > 0) tx_ignore_left--;
                    last_fail = 1'b1;
                end else begin
                    int len;
                    avail_tx = 1'b0;
                    len = tx_rand ? int'($urandom_range(4, 1)) : tx_busy_len;
                    if (err_q.size() > 0) err_code_tx = err_q.pop_front();
                    else if (tx_rand && $urandom_range(3, 0) == 0) err_code_tx = 2'($urandom_range(3, 1));
                    else err_code_tx = 2'b00;
                    repeat (len) @(negedge clk);
                    last_fail = (err_code_tx != 2'b00);
                    avail_tx  = 1'b1;
                end
            end else begin
                avail_tx = 1'b1;
            end
        end
    end

    // Monitor: every start must carry the head packet; sent/dropped must match the attempt history
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start_tx) begin
                    n_start++;
                    check("start_has_packet", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) begin
                        check("start_data2send", data2send, exp_q[0]);
                        if (head_att > 0) begin
                            check("retry_after_fail", last_fail, 1'b1);
                            check("retry_within_limit", (head_att <= MAX_RETRY), 1'b1);
                            model_retry++;
                        end
                        head_att++;
                    end
                end
                if (sent || dropped) begin
                    check("sent_drop_exclusive", (sent & dropped), 1'b0);
                    check("pulse_has_packet", (exp_q.size() > 0), 1'b1);
                    if (sent) begin
                        check("sent_after_success", last_fail, 1'b0);
                        n_sent++;
                    end else begin
                        check("drop_after_last_try", (last_fail && head_att == MAX_RETRY + 1), 1'b1);
                        n_drop++;
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    head_att = 0;
                end
            end
        end
    end

    initial begin
        logic ok;
        int   s0;
        int   d0;
        int   st0;
        int   lat;
        int   k;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0000_0000;
        vecs[0] = '{32'h0000_0001, 48'h3c_00000001_07};
        vecs[1] = '{32'h0000_0080, 48'h3c_00000080_89};
        vecs[2] = '{32'h0000_0000, 48'h3c_00000000_00};

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_data2send", data2send, 48'h0);
        check("rst_start_tx", start_tx, 1'b0);
        check("rst_sent", sent, 1'b0);
        check("rst_dropped", dropped, 1'b0);
        check("rst_busy", busy, 1'b0);
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: latency, framing and a clean send each
        for (int i = 0; i < 3; i++) begin
            s0 = n_sent;
            push_word(vecs[i].word, 10, ok);
            check("vec_push", ok, 1'b1);
            lat = 0;
            while (!start_tx && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("vec_start_latency", lat, 34);
            check("vec_data2send", data2send, vecs[i].pkt);
            wait_drain("vec_drain", 200);
            check("vec_sent", n_sent - s0, 1);
        end

        // Four error results: four identical attempts, then a drop
        s0 = n_sent; d0 = n_drop; st0 = n_start;
        err_q = '{2'b11, 2'b11, 2'b11, 2'b11};
        push_word(32'h1234_5678, 10, ok);
        wait_drain("retry_drain", 600);
        check("retry_starts", n_start - st0, 4);
        check("retry_dropped", n_drop - d0, 1);
        check("retry_no_sent", n_sent - s0, 0);

        // Transmitter never goes busy once: timeout counts as a failure, second attempt succeeds
        s0 = n_sent; st0 = n_start;
        tx_ignore_left = 1;
        push_word(32'ha5a5_0f0f, 10, ok);
        wait_drain("timeout_drain", 400);
        check("timeout_starts", n_start - st0, 2);
        check("timeout_sent", n_sent - s0, 1);

        // Backpressure: four words fill the FIFO, the fifth is held off until the transmitter frees up
        s0 = n_sent;
        tx_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push_word(32'hb000_0000 + 32'(i), 10, ok);
            check("bp_push", ok, 1'b1);
        end
        check("bp_in_ready_full", in_ready, 1'b0);
        in_data  = 32'hb000_0004;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held_off", in_ready, 1'b0);
        end
        tx_hold = 1'b0;
        push_word(32'hb000_0004, 500, ok);
        check("bp_fifth_push", ok, 1'b1);
        wait_drain("bp_drain", 2000);
        check("bp_sent", n_sent - s0, 5);

        // Reset while waiting for the transmitter to finish
        tx_busy_len = 20;
        st0 = n_start;
        push_word(32'hdead_beef, 10, ok);
        k = 0;
        while (n_start == st0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_started", (n_start > st0), 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clear_model();
        check("rstmid_in_ready", in_ready, 1'b1);
        check("rstmid_data2send", data2send, 48'h0);
        check("rstmid_start_tx", start_tx, 1'b0);
        check("rstmid_sent", sent, 1'b0);
        check("rstmid_dropped", dropped, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_start", n_start, 0);
        check("rstmid_no_pulses", n_sent + n_drop, 0);
        check("rstmid_idle", busy, 1'b0);
        check("rstmid_fifo_empty", in_ready, 1'b1);
        tx_busy_len = 3;

        // Three successes and one drop since the reset
        err_q = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            push_word(32'hc0de_0000 + 32'(i), 100, ok);
        end
        wait_drain("stats_drain", 1500);
        check("stats_sent", n_sent, 3);
        check("stats_drop", n_drop, 1);
`ifdef FRAMER_STATS_EN
        check("stats_pkt_sent_cnt", pkt_sent_cnt, 16'd3);
        check("stats_pkt_drop_cnt", pkt_drop_cnt, 16'd1);
        check("stats_retry_cnt_total", retry_cnt_total, 16'd3);
`endif

        // Randomized traffic with random gaps, result codes, busy lengths and timeouts
        s0 = n_sent + n_drop;
        tx_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            push_word($urandom, 2000, ok);
            check("rand_push", ok, 1'b1);
        end
        wait_drain("rand_drain", 20000);
        tx_rand = 1'b0;
        check("rand_all_resolved", n_sent + n_drop - s0, 40);
`ifdef FRAMER_STATS_EN
        check("rand_pkt_sent_cnt", pkt_sent_cnt, 16'(n_sent));
        check("rand_pkt_drop_cnt", pkt_drop_cnt, 16'(n_drop));
        check("rand_retry_cnt_total", retry_cnt_total, 16'(model_retry));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
